// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 19-bit CPU: PC, instruction-memory read requests, instruction register and
// valid/ready hand-off to decode. Optional accepted-instruction counter enabled by IF_FETCH_CNT_EN.
module instr_fetch_unit #(
  parameter int              PC_W     = 19,
  parameter int              INSTR_W  = 19,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OPC = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  input  logic               br_valid,
  input  logic [PC_W-1:0]    br_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [3:0]         opcode,
  output logic [INSTR_W-5:0] operand,
  output logic [PC_W-1:0]    pc_out,
  output logic               halted
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [15:0]        fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    WAIT  = 2'b10,
    HOLD  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 mem_req_q, mem_req_d;
  logic [PC_W-1:0]      mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 halted_q, halted_d;
  // Set when a redirect arrives while a read is in flight; the read's data is then dropped.
  logic                 kill_q, kill_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    ir_d          = ir_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    kill_d        = kill_q;
    case (state_q)
      IDLE: begin
        if (br_valid) begin
          pc_d = br_target;
        end else if (run && !halted_q) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_req_d = 1'b1;
        kill_d    = 1'b0;
        if (br_valid) begin
          pc_d       = br_target;
          mem_addr_d = br_target;
        end else begin
          mem_addr_d = pc_q;
        end
        state_d = WAIT;
      end
      WAIT: begin
        if (br_valid) pc_d = br_target;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          kill_d    = 1'b0;
          if (br_valid || kill_q) begin
            state_d = FETCH;
          end else begin
            ir_d          = mem_rdata;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + PC_W'(1);
            state_d       = HOLD;
          end
        end else if (br_valid) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (br_valid) pc_d = br_target;
          if (ir_q[INSTR_W-1 -: 4] == HALT_OPC) begin
            halted_d = 1'b1;
            state_d  = IDLE;
          end else if (run) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else if (br_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = br_target;
          state_d       = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IF_FETCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == HOLD && instr_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  assign fetch_cnt = cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_PC;
      ir_q          <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      kill_q        <= 1'b0;
`ifdef IF_FETCH_CNT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      ir_q          <= ir_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      kill_q        <= kill_d;
`ifdef IF_FETCH_CNT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = ir_q[INSTR_W-1 -: 4];
  assign operand     = ir_q[INSTR_W-5:0];
  assign pc_out      = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of fetch transactions plus hand-written
// sequences for branches, flush, run drop, PC wrap with halt, and asynchronous reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  // Instance 0: RESET_PC = 0
  logic        run0, ack0, br0, rdy0;
  logic [18:0] rdata0, tgt0;
  logic        req0, ivld0, halt0;
  logic [18:0] addr0, pc0;
  logic [3:0]  op0;
  logic [14:0] opd0;
  // Instance 1: RESET_PC = 0x7FFFF
  logic        run1, ack1, br1, rdy1;
  logic [18:0] rdata1, tgt1;
  logic        req1, ivld1, halt1;
  logic [18:0] addr1, pc1;
  logic [3:0]  op1;
  logic [14:0] opd1;
`ifdef IF_FETCH_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(19), .INSTR_W(19), .RESET_PC(19'h00000), .HALT_OPC(4'hF)) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .mem_req(req0), .mem_addr(addr0),
    .mem_rdata(rdata0), .mem_ack(ack0), .br_valid(br0), .br_target(tgt0),
    .instr_valid(ivld0), .instr_ready(rdy0), .opcode(op0), .operand(opd0),
    .pc_out(pc0), .halted(halt0)
`ifdef IF_FETCH_CNT_EN
    , .fetch_cnt(cnt0)
`endif
  );

  instr_fetch_unit #(.PC_W(19), .INSTR_W(19), .RESET_PC(19'h7FFFF), .HALT_OPC(4'hF)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .mem_req(req1), .mem_addr(addr1),
    .mem_rdata(rdata1), .mem_ack(ack1), .br_valid(br1), .br_target(tgt1),
    .instr_valid(ivld1), .instr_ready(rdy1), .opcode(op1), .operand(opd1),
    .pc_out(pc1), .halted(halt1)
`ifdef IF_FETCH_CNT_EN
    , .fetch_cnt(cnt1)
`endif
  );

  typedef struct {
    logic [18:0] rdata;
    int          ack_wait;
    int          rdy_wait;
    int          lat;
    logic [18:0] addr;
    logic [3:0]  op;
    logic [14:0] opd;
    logic [18:0] pc;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for dut0 to raise mem_req; returns the number of edges waited.
  task automatic wait_req0(output int n);
    n = 0;
    while (!req0 && n < 12) begin
      tick();
      n++;
    end
    chk("req0_seen", 32'(req0), 32'd1);
  endtask

  task automatic do_fetch(input vec_t v);
    int n;
    wait_req0(n);
    chk("req_latency", 32'(n), 32'(v.lat));
    chk("req_addr", 32'(addr0), 32'(v.addr));
    for (int i = 0; i < v.ack_wait; i++) begin
      tick();
      chk("wait_req_held", 32'(req0), 32'd1);
      chk("wait_addr_stable", 32'(addr0), 32'(v.addr));
    end
    ack0 = 1'b1;
    rdata0 = v.rdata;
    tick();
    ack0 = 1'b0;
    rdata0 = 19'h0;
    chk("ivld_after_ack", 32'(ivld0), 32'd1);
    chk("opcode", 32'(op0), 32'(v.op));
    chk("operand", 32'(opd0), 32'(v.opd));
    chk("pc_after_ack", 32'(pc0), 32'(v.pc));
    chk("req_drop", 32'(req0), 32'd0);
    for (int i = 0; i < v.rdy_wait; i++) begin
      tick();
      chk("bp_ivld", 32'(ivld0), 32'd1);
      chk("bp_opcode", 32'(op0), 32'(v.op));
      chk("bp_operand", 32'(opd0), 32'(v.opd));
      chk("bp_no_req", 32'(req0), 32'd0);
    end
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    chk("ivld_after_accept", 32'(ivld0), 32'd0);
  endtask

  initial begin
    int n;
    bit stray_req;
    vecs[0] = '{rdata: 19'h5A5A5, ack_wait: 0, rdy_wait: 0, lat: 2, addr: 19'h0, op: 4'hB, opd: 15'h25A5, pc: 19'h1};
    vecs[1] = '{rdata: 19'h12345, ack_wait: 3, rdy_wait: 5, lat: 1, addr: 19'h1, op: 4'h2, opd: 15'h2345, pc: 19'h2};
    vecs[2] = '{rdata: 19'h00001, ack_wait: 1, rdy_wait: 0, lat: 1, addr: 19'h2, op: 4'h0, opd: 15'h0001, pc: 19'h3};
    vecs[3] = '{rdata: 19'h6FFFF, ack_wait: 0, rdy_wait: 2, lat: 1, addr: 19'h3, op: 4'hD, opd: 15'h7FFF, pc: 19'h4};

    rst_n = 1'b0;
    {run0, ack0, br0, rdy0, run1, ack1, br1, rdy1} = '0;
    rdata0 = '0; tgt0 = '0; rdata1 = '0; tgt1 = '0;
    #12;
    chk("rst_req0", 32'(req0), 32'd0);
    chk("rst_addr0", 32'(addr0), 32'h0);
    chk("rst_pc0", 32'(pc0), 32'h0);
    chk("rst_ivld0", 32'(ivld0), 32'd0);
    chk("rst_op0", 32'({op0, opd0}), 32'h0);
    chk("rst_halt0", 32'(halt0), 32'd0);
    chk("rst_addr1", 32'(addr1), 32'h7FFFF);
    chk("rst_pc1", 32'(pc1), 32'h7FFFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run0 = 1'b1;

    for (int i = 0; i < 4; i++) do_fetch(vecs[i]);

    // Redirect while waiting: returned data must be dropped, refetch from target.
    wait_req0(n);
    chk("br_wait_addr", 32'(addr0), 32'h4);
    br0 = 1'b1; tgt0 = 19'h00100;
    tick();
    br0 = 1'b0;
    chk("br_wait_req_held", 32'(req0), 32'd1);
    chk("br_wait_addr_held", 32'(addr0), 32'h4);
    chk("br_wait_pc", 32'(pc0), 32'h100);
    tick();
    ack0 = 1'b1; rdata0 = 19'h11111;
    tick();
    ack0 = 1'b0;
    chk("br_discard_ivld", 32'(ivld0), 32'd0);
    chk("br_discard_pc", 32'(pc0), 32'h100);
    chk("br_discard_op", 32'(op0), 32'hD);
    tick();
    chk("br_refetch_req", 32'(req0), 32'd1);
    chk("br_refetch_addr", 32'(addr0), 32'h100);

    // Redirect in the same cycle as the acknowledge.
    ack0 = 1'b1; rdata0 = 19'h33333; br0 = 1'b1; tgt0 = 19'h00200;
    tick();
    ack0 = 1'b0; br0 = 1'b0;
    chk("brack_ivld", 32'(ivld0), 32'd0);
    chk("brack_req", 32'(req0), 32'd0);
    chk("brack_pc", 32'(pc0), 32'h200);
    do_fetch('{rdata: 19'h0ABCD, ack_wait: 0, rdy_wait: 0, lat: 1, addr: 19'h200, op: 4'h1, opd: 15'h2BCD, pc: 19'h201});

    // Redirect while holding an unaccepted instruction flushes it.
    wait_req0(n);
    chk("flush_addr", 32'(addr0), 32'h201);
    ack0 = 1'b1; rdata0 = 19'h22222;
    tick();
    ack0 = 1'b0;
    chk("flush_pre_ivld", 32'(ivld0), 32'd1);
    chk("flush_pre_op", 32'(op0), 32'h4);
    br0 = 1'b1; tgt0 = 19'h00300;
    tick();
    br0 = 1'b0;
    chk("flush_ivld", 32'(ivld0), 32'd0);
    chk("flush_pc", 32'(pc0), 32'h300);
`ifdef IF_FETCH_CNT_EN
    chk("fetch_cnt", 32'(cnt0), 32'd5);
`endif
    tick();
    chk("flush_refetch_req", 32'(req0), 32'd1);
    chk("flush_refetch_addr", 32'(addr0), 32'h300);

    // Drop run mid-transaction: complete, accept, then idle.
    run0 = 1'b0;
    ack0 = 1'b1; rdata0 = 19'h4ABCD;
    tick();
    ack0 = 1'b0;
    chk("run0_ivld", 32'(ivld0), 32'd1);
    chk("run0_op", 32'(op0), 32'h9);
    chk("run0_pc", 32'(pc0), 32'h301);
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    chk("run0_accept_ivld", 32'(ivld0), 32'd0);
    stray_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (req0) stray_req = 1'b1;
    end
    chk("run0_idle_no_req", 32'(stray_req), 32'd0);

    // PC wrap and halt on the second instance.
    chk("halt1_init", 32'(halt1), 32'd0);
    run1 = 1'b1;
    n = 0;
    while (!req1 && n < 12) begin
      tick();
      n++;
    end
    chk("wrap_req", 32'(req1), 32'd1);
    chk("wrap_addr", 32'(addr1), 32'h7FFFF);
    ack1 = 1'b1; rdata1 = 19'h7A000;
    tick();
    ack1 = 1'b0;
    chk("wrap_ivld", 32'(ivld1), 32'd1);
    chk("wrap_pc", 32'(pc1), 32'h0);
    chk("wrap_op", 32'(op1), 32'hF);
    chk("wrap_opd", 32'(opd1), 32'h2000);
    chk("halt_before_accept", 32'(halt1), 32'd0);
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    chk("halt_set", 32'(halt1), 32'd1);
    chk("halt_ivld", 32'(ivld1), 32'd0);
    stray_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req1) stray_req = 1'b1;
    end
    chk("halt_no_req", 32'(stray_req), 32'd0);
    chk("halt_sticky", 32'(halt1), 32'd1);

    // Asynchronous reset in the middle of a read.
    run0 = 1'b1;
    wait_req0(n);
    chk("prerst_req", 32'(req0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(req0), 32'd0);
    chk("arst_ivld", 32'(ivld0), 32'd0);
    chk("arst_pc", 32'(pc0), 32'h0);
    chk("arst_op", 32'(op0), 32'h0);
    chk("arst_halt1", 32'(halt1), 32'd0);
    chk("arst_pc1", 32'(pc1), 32'h7FFFF);
    run0 = 1'b0;
    run1 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
